// File: rtl/mips_decode_exec_core.sv
// Decode/execute datapath cluster for the 5-stage MIPS32 pipeline.
// Holds the main control decoder, the 32x32 register file, the ALU-control
// decoder and the 32-bit ALU. Only the register file carries state.
module mips_decode_exec_core #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt,
  input  logic              sinal_escrita,
  input  logic [4:0]        reg_escrita,
  input  logic [DATA_W-1:0] dado_escrita,
  output logic [1:0]        c_ALUOp,
  output logic [1:0]        c_memoria,
  output logic [2:0]        c_desvio,
  output logic              c_fonte_ula,
  output logic              c_memtoreg,
  output logic              c_escrever_reg,
  output logic              c_reg_destino,
  input  logic [5:0]        alu_funct,
  input  logic [1:0]        alu_op_sel,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_operacao,
  output logic [DATA_W-1:0] alu_resultado,
  output logic              alu_zero,
  output logic              alu_overflow
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Main control decode: unknown opcodes fall through to an all-zero nop.
  always_comb begin
    c_ALUOp        = 2'b00;
    c_memoria      = 2'b00;
    c_desvio       = 3'b000;
    c_fonte_ula    = 1'b0;
    c_memtoreg     = 1'b0;
    c_escrever_reg = 1'b0;
    c_reg_destino  = 1'b0;
    case (opcode)
      6'b000000: begin
        c_ALUOp        = 2'b10;
        c_escrever_reg = 1'b1;
        c_reg_destino  = 1'b1;
      end
      6'b100011: begin
        c_memoria      = 2'b01;
        c_fonte_ula    = 1'b1;
        c_memtoreg     = 1'b1;
        c_escrever_reg = 1'b1;
      end
      6'b101011: begin
        c_memoria   = 2'b10;
        c_fonte_ula = 1'b1;
      end
      6'b000100: begin
        c_ALUOp  = 2'b01;
        c_desvio = 3'b001;
      end
      6'b000101: begin
        c_ALUOp  = 2'b01;
        c_desvio = 3'b010;
      end
      6'b001000: begin
        c_fonte_ula    = 1'b1;
        c_escrever_reg = 1'b1;
      end
      6'b000010: c_desvio = 3'b100;
      default: ;
    endcase
  end

  // Register file storage: async clear, r0 never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (sinal_escrita && (reg_escrita != 5'd0)) begin
      regs_q[reg_escrita] <= dado_escrita;
    end
  end

  // Read ports with WB-to-ID write-through; everything reads 0 while in reset.
  always_comb begin
    out_rs = '0;
    out_rt = '0;
    if (reset_n) begin
      if (rs != 5'd0) begin
        if (sinal_escrita && (reg_escrita == rs)) out_rs = dado_escrita;
        else                                      out_rs = regs_q[rs];
      end
      if (rt != 5'd0) begin
        if (sinal_escrita && (reg_escrita == rt)) out_rt = dado_escrita;
        else                                      out_rt = regs_q[rt];
      end
    end
  end

  // ALU-control decode: only the R-type class looks at funct.
  always_comb begin
    alu_operacao = OP_ADD;
    case (alu_op_sel)
      2'b01: alu_operacao = OP_SUB;
      2'b10: begin
        case (alu_funct)
          6'b100010: alu_operacao = OP_SUB;
          6'b100100: alu_operacao = OP_AND;
          6'b100101: alu_operacao = OP_OR;
          6'b100111: alu_operacao = OP_NOR;
          6'b101010: alu_operacao = OP_SLT;
          default:   alu_operacao = OP_ADD;
        endcase
      end
      default: alu_operacao = OP_ADD;
    endcase
  end

  // ALU datapath; overflow is reported but never alters the result.
  always_comb begin
    alu_resultado = '0;
    alu_overflow  = 1'b0;
    case (alu_operacao)
      OP_AND: alu_resultado = alu_a & alu_b;
      OP_OR:  alu_resultado = alu_a | alu_b;
      OP_NOR: alu_resultado = ~(alu_a | alu_b);
      OP_ADD: begin
        alu_resultado = alu_a + alu_b;
        alu_overflow  = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                        (alu_resultado[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_resultado = alu_a - alu_b;
        alu_overflow  = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                        (alu_resultado[DATA_W-1] != alu_a[DATA_W-1]);
      end
      OP_SLT: alu_resultado = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_resultado = '0;
    endcase
  end

  assign alu_zero = (alu_resultado == '0);

endmodule

// File: tb/tb_mips_decode_exec_core.sv
// Directed self-checking bench for mips_decode_exec_core.
module tb_mips_decode_exec_core;

  logic        clock;
  logic        reset_n;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [31:0] out_rs, out_rt;
  logic        sinal_escrita;
  logic [4:0]  reg_escrita;
  logic [31:0] dado_escrita;
  logic [1:0]  c_ALUOp, c_memoria;
  logic [2:0]  c_desvio;
  logic        c_fonte_ula, c_memtoreg, c_escrever_reg, c_reg_destino;
  logic [5:0]  alu_funct;
  logic [1:0]  alu_op_sel;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_operacao;
  logic [31:0] alu_resultado;
  logic        alu_zero, alu_overflow;

  int checkCount = 0;
  int passCount  = 0;

  mips_decode_exec_core #(.NUM_REGS(32), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .rs(rs), .rt(rt),
    .out_rs(out_rs), .out_rt(out_rt), .sinal_escrita(sinal_escrita),
    .reg_escrita(reg_escrita), .dado_escrita(dado_escrita),
    .c_ALUOp(c_ALUOp), .c_memoria(c_memoria), .c_desvio(c_desvio),
    .c_fonte_ula(c_fonte_ula), .c_memtoreg(c_memtoreg),
    .c_escrever_reg(c_escrever_reg), .c_reg_destino(c_reg_destino),
    .alu_funct(alu_funct), .alu_op_sel(alu_op_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_operacao(alu_operacao), .alu_resultado(alu_resultado),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Drives a WB write request at the falling edge.
  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    sinal_escrita = we;
    reg_escrita   = addr;
    dado_escrita  = data;
  endtask

  task automatic checkDecode(input string tag, input logic [5:0] op, input logic [10:0] expected);
    opcode = op;
    #1;
    checkOutput(tag, {21'd0, c_ALUOp, c_memoria, c_desvio, c_fonte_ula,
                      c_memtoreg, c_escrever_reg, c_reg_destino}, {21'd0, expected});
  endtask

  task automatic checkAlu(input string tag, input logic [1:0] sel, input logic [5:0] funct,
                          input logic [31:0] a, input logic [31:0] b, input logic [2:0] expOp,
                          input logic [31:0] expRes, input logic expZero, input logic expOvf);
    alu_op_sel = sel;
    alu_funct  = funct;
    alu_a      = a;
    alu_b      = b;
    #1;
    checkOutput({tag, "_res"}, alu_resultado, expRes);
    checkOutput({tag, "_flags"}, {27'd0, alu_operacao, alu_zero, alu_overflow},
                {27'd0, expOp, expZero, expOvf});
  endtask

  // Main directed sequence.
  initial begin
    reset_n = 1'b0; opcode = 6'd0; rs = 5'd5; rt = 5'd31;
    sinal_escrita = 1'b0; reg_escrita = 5'd0; dado_escrita = 32'd0;
    alu_funct = 6'd0; alu_op_sel = 2'd0; alu_a = 32'd0; alu_b = 32'd0;
    #2;
    checkOutput("reset_rs5", out_rs, 32'd0);
    checkOutput("reset_rt31", out_rt, 32'd0);
    checkDecode("dec_rtype_in_reset", 6'b000000, 11'b10_00_000_0011);

    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 5'd5, 32'h12345678);
    @(posedge clock); #1;
    sinal_escrita = 1'b0;
    #1;
    checkOutput("read_r5", out_rs, 32'h12345678);

    rs = 5'd0;
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    checkOutput("r0_write_pending", out_rs, 32'd0);
    @(posedge clock); #1;
    sinal_escrita = 1'b0;
    #1;
    checkOutput("r0_after_write", out_rs, 32'd0);

    rs = 5'd5; rt = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5);
    #1;
    checkOutput("writethrough_rt7", out_rt, 32'hA5A5A5A5);
    checkOutput("other_port_r5", out_rs, 32'h12345678);
    @(posedge clock); #1;
    sinal_escrita = 1'b0;
    #1;
    checkOutput("stored_r7", out_rt, 32'hA5A5A5A5);

    checkDecode("dec_lw",   6'b100011, 11'b00_01_000_1110);
    checkDecode("dec_sw",   6'b101011, 11'b00_10_000_1000);
    checkDecode("dec_beq",  6'b000100, 11'b01_00_001_0000);
    checkDecode("dec_bne",  6'b000101, 11'b01_00_010_0000);
    checkDecode("dec_addi", 6'b001000, 11'b00_00_000_1010);
    checkDecode("dec_j",    6'b000010, 11'b00_00_100_0000);
    checkDecode("dec_3f",   6'b111111, 11'b0);
    checkDecode("dec_ori",  6'b001101, 11'b0);

    checkAlu("add_ovf",   2'b00, 6'd0, 32'h7FFFFFFF, 32'd1, 3'b010, 32'h80000000, 1'b0, 1'b1);
    checkAlu("sub_zero",  2'b01, 6'd0, 32'd5, 32'd5, 3'b110, 32'd0, 1'b1, 1'b0);
    checkAlu("sub_ovf",   2'b01, 6'd0, 32'h80000000, 32'd1, 3'b110, 32'h7FFFFFFF, 1'b0, 1'b1);
    checkAlu("sel11_add", 2'b11, 6'b100010, 32'd3, 32'd4, 3'b010, 32'd7, 1'b0, 1'b0);
    checkAlu("r_and",     2'b10, 6'b100100, 32'hFFFFFFFF, 32'd1, 3'b000, 32'd1, 1'b0, 1'b0);
    checkAlu("r_or",      2'b10, 6'b100101, 32'hFFFFFFFF, 32'd1, 3'b001, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkAlu("r_nor",     2'b10, 6'b100111, 32'hFFFFFFFF, 32'd1, 3'b100, 32'd0, 1'b1, 1'b0);
    checkAlu("r_slt",     2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    checkAlu("r_slt_neg", 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 3'b111, 32'd0, 1'b1, 1'b0);
    checkAlu("r_unknown", 2'b10, 6'b000000, 32'hFFFFFFFF, 32'd1, 3'b010, 32'd0, 1'b1, 1'b0);
    checkAlu("r_add_ovf", 2'b10, 6'b100000, 32'h80000000, 32'h80000000, 3'b010, 32'd0, 1'b1, 1'b1);
    checkAlu("r_sub",     2'b10, 6'b100010, 32'd1, 32'd2, 3'b110, 32'hFFFFFFFF, 1'b0, 1'b0);

    rs = 5'd3; rt = 5'd5;
    applyStimulus(1'b1, 5'd3, 32'hDEADBEEF);
    @(posedge clock); #1;
    sinal_escrita = 1'b0;
    #1;
    checkOutput("stored_r3", out_rs, 32'hDEADBEEF);

    applyStimulus(1'b1, 5'd3, 32'h11111111);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_r3", out_rs, 32'd0);
    checkOutput("async_rst_r5", out_rt, 32'd0);
    sinal_escrita = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    checkOutput("cleared_r3", out_rs, 32'd0);
    checkOutput("cleared_r5", out_rt, 32'd0);
    @(posedge clock); #1;
    checkOutput("cleared_r3_edge", out_rs, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
